// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel arbiter: FSM encoding, transfer modes
// and the default address width of the 8-entry core memory.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_BURST  = 1'b1;

  localparam int DEFAULT_ADDR_W = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr,
// wrapping modulo NUM_CH. Returns both a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);

  logic             found;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand_idx = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand_idx = IDX_W'((int'(ptr) + off) % NUM_CH);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Shares one DMA core among NUM_CH channels: round-robin grant, one-cycle
// start pulse, then waits for the core's done edge or a timeout.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TMO_CYC = 64,
  localparam int IDX_W  = $clog2(NUM_CH),
  localparam int CNT_W  = $clog2(TMO_CYC + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*ADDR_W-1:0] req_src,
  input  logic [NUM_CH*ADDR_W-1:0] req_dst,
  input  logic [NUM_CH-1:0]        req_mode,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_err,
  output logic                     dma_start,
  output logic [ADDR_W-1:0]        dma_src,
  output logic [ADDR_W-1:0]        dma_dst,
  output logic                     dma_mode,
  input  logic                     dma_done,
  output logic                     busy,
  output logic [IDX_W-1:0]         cur_ch
);

  state_e state_reg, state_next;

  logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic              done_q_reg;
  logic [NUM_CH-1:0] ch_ack_next, ch_done_next, ch_err_next;
  logic              dma_start_next, dma_mode_next, busy_next;
  logic [ADDR_W-1:0] dma_src_next, dma_dst_next;
  logic [IDX_W-1:0]  cur_ch_next;

  logic [ADDR_W-1:0] src_arr [NUM_CH];
  logic [ADDR_W-1:0] dst_arr [NUM_CH];
  logic [NUM_CH-1:0] win_gnt;
  logic [IDX_W-1:0]  win_idx;
  logic              done_rise, tmo_hit;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign src_arr[gi] = req_src[gi*ADDR_W +: ADDR_W];
    assign dst_arr[gi] = req_dst[gi*ADDR_W +: ADDR_W];
  end

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
    .req (req),
    .ptr (rr_ptr_reg),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  // A core that already holds done high when started must not complete the transfer.
  assign done_rise = dma_done & ~done_q_reg;
  assign tmo_hit   = (tmo_cnt_reg == CNT_W'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (|req) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (done_rise || tmo_hit) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_next    = rr_ptr_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    ch_ack_next    = '0;
    ch_done_next   = '0;
    ch_err_next    = '0;
    dma_start_next = 1'b0;
    dma_src_next   = dma_src;
    dma_dst_next   = dma_dst;
    dma_mode_next  = dma_mode;
    cur_ch_next    = cur_ch;
    busy_next      = (state_next != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          dma_src_next  = src_arr[win_idx];
          dma_dst_next  = dst_arr[win_idx];
          dma_mode_next = req_mode[win_idx];
          cur_ch_next   = win_idx;
          ch_ack_next   = win_gnt;
          rr_ptr_next   = (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      ST_ISSUE: begin
        dma_start_next = 1'b1;
        tmo_cnt_next   = '0;
      end
      ST_WAIT: begin
        // Completion takes priority when it coincides with the timeout.
        if (done_rise)    ch_done_next = NUM_CH'(1) << cur_ch;
        else if (tmo_hit) ch_err_next  = NUM_CH'(1) << cur_ch;
        else              tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg  <= '0;
      tmo_cnt_reg <= '0;
      done_q_reg  <= 1'b0;
      ch_ack      <= '0;
      ch_done     <= '0;
      ch_err      <= '0;
      dma_start   <= 1'b0;
      dma_src     <= '0;
      dma_dst     <= '0;
      dma_mode    <= 1'b0;
      busy        <= 1'b0;
      cur_ch      <= '0;
    end else begin
      rr_ptr_reg  <= rr_ptr_next;
      tmo_cnt_reg <= tmo_cnt_next;
      done_q_reg  <= dma_done;
      ch_ack      <= ch_ack_next;
      ch_done     <= ch_done_next;
      ch_err      <= ch_err_next;
      dma_start   <= dma_start_next;
      dma_src     <= dma_src_next;
      dma_dst     <= dma_dst_next;
      dma_mode    <= dma_mode_next;
      busy        <= busy_next;
      cur_ch      <= cur_ch_next;
    end
  end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Randomized scoreboard bench for dma_channel_arbiter: a driver plays requesters
// and the core, a monitor pops expected grants/completions and compares.
module tb_dma_channel_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 3;
  localparam int TMO    = 16;
  localparam int NEVER  = 1000;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        req = '0;
  logic [NUM_CH*ADDR_W-1:0] req_src = '0;
  logic [NUM_CH*ADDR_W-1:0] req_dst = '0;
  logic [NUM_CH-1:0]        req_mode = '0;
  logic                     dma_done = 1'b0;
  logic [NUM_CH-1:0]        ch_ack, ch_done, ch_err;
  logic                     dma_start, dma_mode, busy;
  logic [ADDR_W-1:0]        dma_src, dma_dst;
  logic [1:0]               cur_ch;

  dma_channel_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_src(req_src), .req_dst(req_dst),
    .req_mode(req_mode), .ch_ack(ch_ack), .ch_done(ch_done), .ch_err(ch_err),
    .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_mode(dma_mode),
    .dma_done(dma_done), .busy(busy), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           ch;
    logic [2:0]   src;
    logic [2:0]   dst;
    logic         mode;
    bit           err;
    int           delta;
  } exp_t;

  exp_t ack_q[$];
  exp_t comp_q[$];
  exp_t m_e;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int model_ptr = 0;
  logic [2:0] d_src [NUM_CH];
  logic [2:0] d_dst [NUM_CH];
  logic       d_mode [NUM_CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort_run(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT event did not arrive within its cycle budget", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Reference arbitration rule: first requester at or after the pointer.
  function automatic int winner(input logic [NUM_CH-1:0] r, input int ptr);
    for (int off = 0; off < NUM_CH; off++) begin
      if (r[(ptr + off) % NUM_CH]) return (ptr + off) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic pack_desc();
    for (int i = 0; i < NUM_CH; i++) begin
      req_src[i*ADDR_W +: ADDR_W] = d_src[i];
      req_dst[i*ADDR_W +: ADDR_W] = d_dst[i];
      req_mode[i] = d_mode[i];
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ack", ch_ack, 0);
    check("rst_done", ch_done, 0);
    check("rst_err", ch_err, 0);
    check("rst_start", dma_start, 0);
    check("rst_src", dma_src, 0);
    check("rst_dst", dma_dst, 0);
    check("rst_mode", dma_mode, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_ch", cur_ch, 0);
  endtask

  // One transfer: add requesters, predict the winner, play the core.
  // abort_at > 0 pulses reset that many cycles after dma_start instead.
  task automatic run_txn(input logic [NUM_CH-1:0] add_mask, input int lat,
                         input bit stale, input bit keep_desc, input int abort_at);
    logic [NUM_CH-1:0] newbits;
    exp_t e;
    int   w;
    bit   seen;
    if ((req | add_mask) == '0) add_mask[$urandom_range(0, NUM_CH-1)] = 1'b1;
    newbits = add_mask & ~req;
    for (int i = 0; i < NUM_CH; i++) begin
      if (newbits[i] && !keep_desc) begin
        d_src[i]  = 3'($urandom_range(0, 7));
        d_dst[i]  = 3'($urandom_range(0, 7));
        d_mode[i] = 1'($urandom_range(0, 1));
      end
    end
    pack_desc();
    req = req | add_mask;
    w = winner(req, model_ptr);
    model_ptr = (w + 1) % NUM_CH;
    e.ch = w; e.src = d_src[w]; e.dst = d_dst[w]; e.mode = d_mode[w];
    e.err = (lat > TMO - 1);
    e.delta = e.err ? TMO : lat + 1;
    ack_q.push_back(e);
    comp_q.push_back(e);
    if (stale) dma_done = 1'b1;

    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (ch_ack != '0) seen = 1'b1;
    end
    if (!seen) abort_run("ack_wait");
    req[w] = 1'b0;

    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(posedge clk); #1;
      if (dma_start) seen = 1'b1;
    end
    if (!seen) abort_run("start_wait");

    seen = 1'b0;
    for (int d = 1; d <= TMO + 4 && !seen; d++) begin
      @(posedge clk); #1;
      if (abort_at > 0 && d == abort_at) begin
        rst = 1'b1;
        comp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs();
        model_ptr = 0;
        seen = 1'b1;
      end else begin
        if (stale && d == 1) dma_done = 1'b0;
        if (d == lat) dma_done = 1'b1;
        if ((ch_done | ch_err) != '0) seen = 1'b1;
      end
    end
    if (!seen) abort_run("completion_wait");
    dma_done = 1'b0;
  endtask

  // Monitor: every DUT pulse is matched against the head of a queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (ch_ack != '0) begin
        if (ack_q.size() == 0) check("unexpected_ack", ch_ack, 0);
        else begin
          m_e = ack_q.pop_front();
          check("ack", ch_ack, 32'(1) << m_e.ch);
          check("cur_ch", cur_ch, m_e.ch);
          check("busy_at_ack", busy, 1);
        end
      end
      if (dma_start) begin
        if (comp_q.size() == 0) check("unexpected_start", dma_start, 0);
        else begin
          m_e = comp_q[0];
          check("start_src", dma_src, m_e.src);
          check("start_dst", dma_dst, m_e.dst);
          check("start_mode", dma_mode, m_e.mode);
          check("start_busy", busy, 1);
          start_cyc = cyc;
        end
      end
      if ((ch_done | ch_err) != '0) begin
        if (comp_q.size() == 0) check("unexpected_completion", {ch_done, ch_err}, 0);
        else begin
          m_e = comp_q.pop_front();
          check("ch_done", ch_done, m_e.err ? 32'(0) : 32'(1) << m_e.ch);
          check("ch_err", ch_err, m_e.err ? 32'(1) << m_e.ch : 32'(0));
          check("latency", cyc - start_cyc, m_e.delta);
          check("busy_after", busy, 0);
          check("held_src", dma_src, m_e.src);
          $display("txn ch=%0d src=%0d dst=%0d mode=%0d %s after %0d cycles",
                   m_e.ch, m_e.src, m_e.dst, m_e.mode, m_e.err ? "timeout" : "done",
                   cyc - start_cyc);
        end
      end
    end
  end

  int lat_r;
  bit stale_r;

  task automatic pick_lat(output int lat, output bit stale);
    int r;
    r = $urandom_range(0, 9);
    stale = 1'b0;
    if (r <= 5)      lat = $urandom_range(1, 8);
    else if (r == 6) lat = TMO - 1;
    else if (r == 7) lat = TMO;
    else if (r == 8) lat = NEVER;
    else begin
      lat = $urandom_range(3, 8);
      stale = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      d_src[i] = '0; d_dst[i] = '0; d_mode[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    d_src[0] = 3'd0; d_dst[0] = 3'd4; d_mode[0] = 1'b0;
    run_txn(4'b0001, 5, 1'b0, 1'b1, 0);
    run_txn(4'b0100, NEVER, 1'b0, 1'b0, 0);
    run_txn(4'b0010, 6, 1'b1, 1'b0, 0);
    run_txn(4'b0011, 4, 1'b0, 1'b0, 0);
    run_txn(4'b0011, 3, 1'b0, 1'b0, 0);
    for (int t = 0; t < 5; t++) run_txn(4'b1111, $urandom_range(1, 8), 1'b0, 1'b0, 0);
    for (int t = 0; t < 30; t++) begin
      pick_lat(lat_r, stale_r);
      run_txn(4'($urandom_range(0, 15)), lat_r, stale_r, 1'b0, 0);
    end

    req = '0;
    run_txn(4'b0100, NEVER, 1'b0, 1'b0, 4);
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_quiet", {ch_ack, ch_done, ch_err, dma_start}, 0);
    end
    run_txn(4'b0110, 2, 1'b0, 1'b0, 0);
    req = '0;
    run_txn(4'b1000, 3, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("ack_q_empty", ack_q.size(), 0);
    check("comp_q_empty", comp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
